// File: rtl/reg_file_mp.sv
// reg_file_mp
// Architectural register file for the CPU. It has NUM_READ combinational read
// ports, one write port, and a pending-producer scoreboard that issue uses to
// stall. A clear sequencer sweeps every register back to zero, one register
// per cycle.
//
// Ports
//   clk, reset_n          clock (rising edge) and asynchronous active-low reset
//   rd_num / rd_val       packed read indices / read data; port k is in slice k
//   rd_busy               per-port pending flag for the indexed register
//   wr_en/wr_num/wr_val   writeback port; a write also clears the pending flag
//   claim_en/claim_num    marks a register as having an in-flight producer
//   clr_req / clr_busy    starts a clear sweep / sweep in progress
module reg_file_mp #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_INDEX     = 5,
  parameter int REG_FILE_SIZE = 32,
  parameter int NUM_READ      = 3,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_READ*REG_INDEX-1:0] rd_num,
  output logic [NUM_READ*WORD_SIZE-1:0] rd_val,
  output logic [NUM_READ-1:0]           rd_busy,
  input  logic                          wr_en,
  input  logic [REG_INDEX-1:0]          wr_num,
  input  logic [WORD_SIZE-1:0]          wr_val,
  input  logic                          claim_en,
  input  logic [REG_INDEX-1:0]          claim_num,
  input  logic                          clr_req,
  output logic                          clr_busy
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // One bit wider than the index so the counter never wraps inside a sweep.
  localparam logic [REG_INDEX:0] LAST_IDX = (REG_INDEX+1)'(REG_FILE_SIZE - 1);
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [WORD_SIZE-1:0]     mem_q [REG_FILE_SIZE];
  logic [WORD_SIZE-1:0]     mem_d [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] pend_q, pend_d;
  state_t                   state_q, state_d;
  logic [REG_INDEX:0]       cnt_q, cnt_d;

  logic idle;
  logic wr_ok;
  logic claim_ok;

  assign idle     = (state_q == IDLE);
  // Writes and claims are dropped while sweeping and when aimed at r0.
  assign wr_ok    = idle && wr_en && !(HAS_ZERO && (wr_num == '0));
  assign claim_ok = idle && claim_en && !(HAS_ZERO && (claim_num == '0));
  assign clr_busy = (state_q == SWEEP);

  // Sequencer next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + (REG_INDEX+1)'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage next state. The claim is applied after the write so that a
  // same-cycle write and claim of one register leaves it pending.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (state_q == SWEEP) begin
      mem_d[cnt_q[REG_INDEX-1:0]]  = '0;
      pend_d[cnt_q[REG_INDEX-1:0]] = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_num]  = wr_val;
        pend_d[wr_num] = 1'b0;
      end
      if (claim_ok) begin
        pend_d[claim_num] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read ports.
  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [REG_INDEX-1:0] idx;
      logic                 is_zero;
      logic                 fwd;

      assign idx     = rd_num[gi*REG_INDEX +: REG_INDEX];
      assign is_zero = HAS_ZERO && (idx == '0);
      // Forwarding is only active while idle; wr_ok already excludes r0.
      assign fwd     = HAS_BYP && wr_ok && (wr_num == idx);

      always_comb begin
        rd_val[gi*WORD_SIZE +: WORD_SIZE] = mem_q[idx];
        rd_busy[gi]                       = pend_q[idx];
        if (is_zero) begin
          rd_val[gi*WORD_SIZE +: WORD_SIZE] = '0;
          rd_busy[gi]                       = 1'b0;
        end else if (fwd) begin
          rd_val[gi*WORD_SIZE +: WORD_SIZE] = wr_val;
          // A write retires the pending producer unless a new one claims the
          // register in the same cycle; claims themselves are not forwarded.
          if (!(claim_ok && (claim_num == idx))) begin
            rd_busy[gi] = 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int WS = 32;
  localparam int RI = 5;
  localparam int RS = 32;
  localparam int NR = 3;

  logic              clk;
  logic              reset_n;
  logic [NR*RI-1:0]  rd_num;
  logic [NR*WS-1:0]  rd_val;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [RI-1:0]     wr_num;
  logic [WS-1:0]     wr_val;
  logic              claim_en;
  logic [RI-1:0]     claim_num;
  logic              clr_req;
  logic              clr_busy;

  int checks;
  int failures;

  reg_file_mp #(
    .WORD_SIZE(WS), .REG_INDEX(RI), .REG_FILE_SIZE(RS),
    .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_num(rd_num), .rd_val(rd_val), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_num(wr_num), .wr_val(wr_val),
    .claim_en(claim_en), .claim_num(claim_num),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_rd(input int p, input int idx);
    rd_num[p*RI +: RI] = RI'(idx);
  endtask

  function automatic logic [WS-1:0] val_of(input int p);
    return rd_val[p*WS +: WS];
  endfunction

  task automatic idle_inputs();
    wr_en = 1'b0; wr_num = '0; wr_val = '0;
    claim_en = 1'b0; claim_num = '0; clr_req = 1'b0;
  endtask

  task automatic write_reg(input int idx, input logic [WS-1:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_num = RI'(idx); wr_val = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < RS; i++) begin
      for (int p = 0; p < NR; p++) set_rd(p, (i + p) % RS);
      #1;
      checks++;
      if (val_of(0) !== '0 || val_of(1) !== '0 || val_of(2) !== '0 || rd_busy !== '0) begin
        failures++;
        $display("FAIL %s idx=%0d val=%h/%h/%h busy=%b required all 0",
                 tag, i, val_of(0), val_of(1), val_of(2), rd_busy);
      end
    end
  endtask

  // Runs a sweep from a clr_req pulse and counts clr_busy-high cycles.
  // Optionally tries a write to r3 and a repeat clr_req mid-sweep.
  task automatic run_sweep(input bit poke, output int n);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (poke && n == 5) begin
        wr_en = 1'b1; wr_num = 5'd3; wr_val = 32'h77;
        set_rd(0, 3);
        #1;
        checks++;
        if (val_of(0) !== 32'h0) begin
          failures++;
          $display("FAIL sweep_no_bypass got=%h required=0", val_of(0));
        end
      end
      if (poke && n == 10) clr_req = 1'b1;
      n++;
      @(posedge clk); #1;
      wr_en = 1'b0; clr_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_num = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_clr_busy got=%b required=0", clr_busy);
    end
    check_all_zero("reset_read");
    $display("reset: done");
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1; wr_num = 5'd5; wr_val = 32'hDEADBEEF;
    set_rd(0, 5);
    #1;
    checks++;
    if (val_of(0) !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h required=deadbeef", val_of(0));
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    #1;
    checks++;
    if (val_of(0) !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_array got=%h required=deadbeef", val_of(0));
    end
    $display("bypass: r5 write/read");
  endtask

  task automatic test_claim();
    @(negedge clk);
    claim_en = 1'b1; claim_num = 5'd7;
    set_rd(1, 7);
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL claim_no_forward got=%b required=0", rd_busy[1]);
    end
    @(posedge clk); #1;
    claim_en = 1'b0;
    #1;
    checks++;
    if (rd_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL claim_busy got=%b required=1", rd_busy[1]);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_num = 5'd7; wr_val = 32'd42;
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0 || val_of(1) !== 32'd42) begin
      failures++;
      $display("FAIL write_bypass_busy busy=%b val=%0d required busy=0 val=42", rd_busy[1], val_of(1));
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_busy[1] !== 1'b0 || val_of(1) !== 32'd42) begin
      failures++;
      $display("FAIL write_retire busy=%b val=%0d required busy=0 val=42", rd_busy[1], val_of(1));
    end
    // Simultaneous write and claim: data written, pending ends set.
    @(negedge clk);
    wr_en = 1'b1; wr_num = 5'd7; wr_val = 32'd99;
    claim_en = 1'b1; claim_num = 5'd7;
    #1;
    checks++;
    if (val_of(1) !== 32'd99 || rd_busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL claim_write_same busy=%b val=%0d required busy=0 val=99", rd_busy[1], val_of(1));
    end
    @(posedge clk); #1;
    wr_en = 1'b0; claim_en = 1'b0;
    #1;
    checks++;
    if (rd_busy[1] !== 1'b1 || val_of(1) !== 32'd99) begin
      failures++;
      $display("FAIL claim_write_after busy=%b val=%0d required busy=1 val=99", rd_busy[1], val_of(1));
    end
    $display("claim: r7 claim/write sequence");
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wr_en = 1'b1; wr_num = 5'd0; wr_val = 32'h1234;
    claim_en = 1'b1; claim_num = 5'd0;
    set_rd(2, 0);
    #1;
    checks++;
    if (val_of(2) !== 32'h0 || rd_busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL zero_same_cycle val=%h busy=%b required 0/0", val_of(2), rd_busy[2]);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; claim_en = 1'b0;
    #1;
    checks++;
    if (val_of(2) !== 32'h0 || rd_busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL zero_after val=%h busy=%b required 0/0", val_of(2), rd_busy[2]);
    end
    $display("zero_reg: r0 write/claim dropped");
  endtask

  task automatic test_sweep();
    int n;
    for (int i = 1; i < RS; i++) write_reg(i, WS'(i));
    set_rd(0, 3); set_rd(1, 31); set_rd(2, 16);
    #1;
    checks++;
    if (val_of(0) !== 32'd3 || val_of(1) !== 32'd31 || val_of(2) !== 32'd16) begin
      failures++;
      $display("FAIL fill got=%0d/%0d/%0d required 3/31/16", val_of(0), val_of(1), val_of(2));
    end
    run_sweep(1'b1, n);
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL sweep_len got=%0d required=32", n);
    end
    @(posedge clk); #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_req_ignored clr_busy=%b required=0", clr_busy);
    end
    check_all_zero("sweep_cleared");
    $display("sweep: busy cycles=%0d", n);
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    write_reg(20, 32'h55);
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (clr_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_busy got=%b required=1", clr_busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL async_abort clr_busy=%b required=0", clr_busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle clr_busy=%b required=0", clr_busy);
    end
    run_sweep(1'b0, n);
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL resweep_len got=%0d required=32", n);
    end
    $display("reset_mid_sweep: resweep cycles=%0d", n);
  endtask

  task automatic test_post_sweep_write();
    write_reg(9, 32'hA5A5A5A5);
    set_rd(2, 9);
    #1;
    checks++;
    if (val_of(2) !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL post_sweep_write got=%h required=a5a5a5a5", val_of(2));
    end
    $display("post_sweep_write: r9");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_bypass();
    test_claim();
    test_zero_reg();
    test_sweep();
    test_reset_mid_sweep();
    test_post_sweep_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
